// File: rtl/uart_frame_decoder.sv
// Framed byte-stream decoder: SOF, LEN, payload[LEN], CSUM; releases only checksum-verified payloads.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
   parameter int unsigned      WIDTH          = 8,
   parameter logic [WIDTH-1:0] SOF            = 8'hA5,
   parameter int unsigned      MAX_LEN        = 16,
   parameter int unsigned      TIMEOUT_CYCLES = 1000
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic             busy
);

   localparam int unsigned      PW        = $clog2(MAX_LEN + 1);
   localparam int unsigned      AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [WIDTH-1:0] MAX_LEN_W = WIDTH'(MAX_LEN);

   if (MAX_LEN < 1 || PW > WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("uart_frame_decoder: unsupported parameter combination");
   end

   typedef enum logic [2:0] {S_HUNT, S_LEN, S_BODY, S_CHECK, S_DRAIN} state_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT} err_t;

   state_t           state_q, state_n;
   err_t             code_q, code_n;
   logic             ok_q, ok_n, err_q, err_n;
   logic [PW-1:0]    len_q, wr_q, rd_q;
   logic [PW-1:0]    len_last;
   logic [WIDTH-1:0] sum_q, csum_total;
   logic [WIDTH-1:0] payload_mem [MAX_LEN];
   logic             accept, drain_xfer, timeout_hit;

   assign in_ready   = (state_q != S_DRAIN);
   assign out_valid  = (state_q == S_DRAIN);
   assign busy       = (state_q != S_HUNT);
   assign accept     = in_valid && in_ready;
   assign len_last   = len_q - PW'(1);
   assign csum_total = sum_q + in_data;
   assign out_data   = out_valid ? payload_mem[rd_q[AW-1:0]] : '0;
   assign out_last   = out_valid && (rd_q == len_last);
   assign drain_xfer = out_valid && out_ready;
   assign frame_ok   = ok_q;
   assign frame_err  = err_q;
   assign err_code   = code_q;

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_q;
   logic          in_frame;

   // Counts idle clocks only while a frame is being assembled; any accepted byte restarts it.
   assign in_frame    = (state_q == S_LEN) || (state_q == S_BODY) || (state_q == S_CHECK);
   assign timeout_hit = in_frame && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                idle_q <= '0;
      else if (accept || !in_frame) idle_q <= '0;
      else                        idle_q <= idle_q + TW'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      ok_n    = 1'b0;
      err_n   = 1'b0;
      code_n  = ERR_NONE;
      case (state_q)
         S_HUNT:  if (accept && in_data == SOF) state_n = S_LEN;
         S_LEN:
            if (accept) begin
               if (in_data > MAX_LEN_W) begin
                  err_n   = 1'b1;
                  code_n  = ERR_LEN;
                  state_n = S_HUNT;
               end else if (in_data == '0) begin
                  state_n = S_CHECK;
               end else begin
                  state_n = S_BODY;
               end
            end
         S_BODY:  if (accept && wr_q == len_last) state_n = S_CHECK;
         S_CHECK:
            if (accept) begin
               if (csum_total == '0) begin
                  ok_n    = 1'b1;
                  state_n = (len_q == '0) ? S_HUNT : S_DRAIN;
               end else begin
                  err_n   = 1'b1;
                  code_n  = ERR_CSUM;
                  state_n = S_HUNT;
               end
            end
         S_DRAIN: if (drain_xfer && out_last) state_n = S_HUNT;
         default: state_n = S_HUNT;
      endcase
      if (timeout_hit) begin
         err_n   = 1'b1;
         code_n  = ERR_TIMEOUT;
         state_n = S_HUNT;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_HUNT;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         len_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_n;
         ok_q    <= ok_n;
         err_q   <= err_n;
         code_q  <= code_n;
         case (state_q)
            S_LEN:
               if (accept) begin
                  len_q <= in_data[PW-1:0];
                  sum_q <= in_data;
                  wr_q  <= '0;
               end
            S_BODY:
               if (accept) begin
                  sum_q <= csum_total;
                  wr_q  <= wr_q + PW'(1);
               end
            S_CHECK: if (accept) rd_q <= '0;
            S_DRAIN: if (drain_xfer) rd_q <= rd_q + PW'(1);
            default: ;
         endcase
      end
   end

   // Payload storage is deliberately not reset; only checksum-verified data is ever read out.
   always_ff @(posedge clock) begin
      if (state_q == S_BODY && accept) payload_mem[wr_q[AW-1:0]] <= in_data;
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with an output scoreboard of expected {last, data} bytes.
// Timeout case runs only when FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_decoder;

   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   int         compared   = 0;
   int         mismatched = 0;
   int         ok_seen    = 0;
   int         err_seen   = 0;
   int         exp_ok     = 0;
   int         exp_err    = 0;
   logic [8:0] sb[$];
   logic       stall_q    = 1'b0;
   logic [8:0] hold_q     = '0;

   uart_frame_decoder #(
      .WIDTH(8), .SOF(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clock(clock), .resetn(resetn),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one byte and waits for its handshake; returns #1 after the accepting edge.
   task automatic put(input logic [7:0] b);
      int   n = 0;
      logic rdy;
      in_data  = b;
      in_valid = 1'b1;
      do begin
         @(negedge clock);
         rdy = in_ready;
         @(posedge clock);
         #1;
         n++;
      end while (!rdy && n < 50);
      in_valid = 1'b0;
      chk("put_accept", rdy, 1'b1);
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic last);
      sb.push_back({last, d});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("drain_done", sb.size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Sends a frame whose checksum is derived here; a corrupted frame expects no output.
   task automatic send_frame(input int n, input logic [7:0] seed, input logic bad);
      logic [7:0] sum = 8'(n);
      logic [7:0] p;
      put(8'hA5);
      put(8'(n));
      for (int i = 0; i < n; i++) begin
         p = seed + 8'(i * 7);
         sum += p;
         if (!bad) expect_byte(p, i == n - 1);
         put(p);
      end
      put(bad ? 8'(-sum) + 8'd1 : 8'(-sum));
   endtask

   always @(negedge clock) begin
      if (!resetn) begin
         stall_q = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
            else chk("out_byte", {out_last, out_data}, sb.pop_front());
         end
         if (stall_q) chk("stall_hold", {out_last, out_data}, hold_q);
         stall_q = out_valid && !out_ready;
         hold_q  = {out_last, out_data};
         chk("ok_err_excl", frame_ok && frame_err, 1'b0);
         if (!frame_err) chk("code_idle", err_code, 2'd0);
         if (frame_ok) ok_seen++;
         if (frame_err) err_seen++;
      end
   end

   initial begin
      resetn    = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_outs", {out_valid, out_last, frame_ok, frame_err, err_code, busy, out_data}, '0);
      @(negedge clock) resetn = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_ready", in_ready, 1'b1);

      // Spec good frame
      expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
      put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33);
      chk("t1_busy", busy, 1'b1);
      put(8'h97);
      exp_ok++;
      chk("t1_ok", frame_ok, 1'b1);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_first", out_data, 8'h11);
      chk("t1_in_ready", in_ready, 1'b0);
      wait_drain();
      chk("t1_idle", {busy, in_ready}, 2'b01);

      // Noise ahead of a good frame
      put(8'h00); put(8'hFF); put(8'h5A);
      chk("t2_noise_hunt", busy, 1'b0);
      expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
      put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h97);
      exp_ok++;
      chk("t2_ok", frame_ok, 1'b1);
      wait_drain();
      chk("t2_no_err", err_seen, exp_err);

      // Bad checksum
      put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h96);
      exp_err++;
      chk("t3_err", {frame_err, err_code}, 3'b110);
      chk("t3_no_out", {out_valid, busy, frame_ok}, 3'b000);
      idle(1);
      chk("t3_pulse", frame_err, 1'b0);

      // LEN over MAX_LEN, then a fresh frame right after
      put(8'hA5); put(8'h11);
      exp_err++;
      chk("t4_err", {frame_err, err_code}, 3'b101);
      chk("t4_hunt", busy, 1'b0);
      expect_byte(8'h7F, 1'b1);
      put(8'hA5); put(8'h01); put(8'h7F); put(8'h80);
      exp_ok++;
      chk("t4_next_ok", frame_ok, 1'b1);
      wait_drain();

      // Empty payload
      put(8'hA5); put(8'h00); put(8'h00);
      exp_ok++;
      chk("t5_ok", frame_ok, 1'b1);
      chk("t5_no_out", {out_valid, busy}, 2'b00);

      // Maximum length frame, and one corrupted at maximum length
      send_frame(16, 8'h3C, 1'b0);
      exp_ok++;
      chk("t6_ok", frame_ok, 1'b1);
      wait_drain();
      send_frame(16, 8'h01, 1'b1);
      exp_err++;
      chk("t6_bad", {frame_err, err_code}, 3'b110);

      // Consumer stall mid-drain; SOF inside payload is plain data
      expect_byte(8'hA5, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
      put(8'hA5); put(8'h03); put(8'hA5); put(8'h22); put(8'h33); put(8'h03);
      exp_ok++;
      chk("t7_ok", frame_ok, 1'b1);
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk("t7_second", out_data, 8'h22);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         chk("t7_stall", {in_ready, out_valid, out_data}, {2'b01, 8'h22});
      end
      out_ready = 1'b1;
      wait_drain();

      // Reset mid-BODY aborts silently
      put(8'hA5); put(8'h05); put(8'h01); put(8'h02);
      chk("t8_busy", busy, 1'b1);
      resetn = 1'b0;
      #2;
      chk("t8_rst_outs", {busy, out_valid, frame_err, frame_ok, in_ready}, 5'b00001);
      @(negedge clock) resetn = 1'b1;
      @(posedge clock);
      #1;
      expect_byte(8'h7F, 1'b1);
      put(8'hA5); put(8'h01); put(8'h7F); put(8'h80);
      exp_ok++;
      chk("t8_ok", frame_ok, 1'b1);
      wait_drain();

`ifdef FRAME_TIMEOUT_EN
      begin
         int n = 0;
         put(8'hA5); put(8'h02); put(8'h11);
         while (!frame_err && n < 1100) begin
            @(posedge clock);
            #1;
            n++;
         end
         exp_err++;
         chk("t9_cycles", n, 1000);
         chk("t9_err", {frame_err, err_code, busy}, 4'b1110);
      end
`endif

      idle(2);
      chk("ok_total", ok_seen, exp_ok);
      chk("err_total", err_seen, exp_err);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
